// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the MEM-stage data port: TX data register, status register, small byte FIFO.
// Define UART_TX_IRQ_EN to build the registered TX-empty interrupt; otherwise irq is tied low.
module uart_tx_mmio #(
   parameter int unsigned CLKS_PER_BIT    = 868,
   parameter int unsigned FIFO_DEPTH_LOG2 = 2,
   parameter logic [31:0] BASE_ADDR       = 32'h40000018
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Hit,
   output logic        tx,
   output logic        irq
);

   localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;
   localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
   localparam logic [15:0] BAUD_LAST   = 16'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
   localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE = FIFO_DEPTH_LOG2'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_e;

   state_e                      state_q, state_d;
   logic [15:0]                 baud_q, baud_d;
   logic [2:0]                  bit_idx_q, bit_idx_d;
   logic [7:0]                  shift_q, shift_d;
   logic                        tx_q, tx_d;
   logic [FIFO_DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
   logic [FIFO_DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]               count_q, count_d;
   logic                        overflow_q, overflow_d;
   logic [7:0]                  fifo_mem_q [DEPTH];

   logic        data_sel_s, stat_sel_s;
   logic        push_req_s, push_s, pop_s, clr_req_s;
   logic        full_s, empty_s, busy_s, baud_end_s;
   logic [7:0]  head_s;
   logic [31:0] status_s;
   logic        unused_wdata_s;

   assign data_sel_s     = (Address == BASE_ADDR);
   assign stat_sel_s     = (Address == STATUS_ADDR);
   assign push_req_s     = MemWrite & data_sel_s;
   assign clr_req_s      = MemWrite & stat_sel_s & WriteData[3];
   assign full_s         = (count_q == FULL_COUNT);
   assign empty_s        = (count_q == CNT_ZERO);
   assign busy_s         = (state_q != S_IDLE);
   assign baud_end_s     = (baud_q == BAUD_LAST);
   assign head_s         = fifo_mem_q[rd_ptr_q];
   // A full FIFO still accepts a byte when the serializer pops on the same edge.
   assign push_s         = push_req_s & (~full_s | pop_s);
   assign unused_wdata_s = ^WriteData[31:8];
   assign status_s       = {23'd0, 5'(count_q), overflow_q, empty_s, full_s, busy_s};
   assign Hit            = data_sel_s | stat_sel_s;
   assign tx             = tx_q;

   // Status readback mux; everything except a status read returns zero.
   always_comb begin
      ReadData = 32'd0;
      if (MemRead && stat_sel_s) begin
         ReadData = status_s;
      end else begin
         ReadData = 32'd0;
      end
   end

   // FIFO pointer, occupancy and sticky overflow next-state.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      if (push_req_s && !push_s) begin
         overflow_d = 1'b1;
      end else if (clr_req_s) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // Serializer FSM: next state, baud/bit counters, shift register, pop and registered line value.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      pop_s     = 1'b0;
      tx_d      = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (!empty_s) begin
               pop_s   = 1'b1;
               shift_d = head_s;
               baud_d  = 16'd0;
               state_d = S_START;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (baud_end_s) begin
               baud_d    = 16'd0;
               bit_idx_d = 3'd0;
               state_d   = S_DATA;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_DATA: begin
            if (baud_end_s) begin
               baud_d  = 16'd0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_STOP: begin
            if (baud_end_s) begin
               baud_d = 16'd0;
               // Chain straight into the next start bit when more data is waiting.
               if (!empty_s) begin
                  pop_s   = 1'b1;
                  shift_d = head_s;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: begin
            state_d   = S_IDLE;
            baud_d    = 16'd0;
            bit_idx_d = 3'd0;
         end
      endcase
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   // State and control registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         baud_q     <= 16'd0;
         bit_idx_q  <= 3'd0;
         shift_q    <= 8'd0;
         tx_q       <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= CNT_ZERO;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // FIFO storage; stale contents are unreachable once the pointers reset.
   always_ff @(posedge clk) begin
      if (push_s && !reset) begin
         fifo_mem_q[wr_ptr_q] <= WriteData[7:0];
      end
   end

`ifdef UART_TX_IRQ_EN
   logic irq_q, irq_d;

   assign irq_d = (count_d == CNT_ZERO) && (state_d == S_IDLE);
   assign irq   = irq_q;

   // TX-empty interrupt level, registered from next-state so a push drops it on its own edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomized scoreboard bench for uart_tx_mmio: bytes written are queued as expected frames and
// a line monitor decodes tx cycle by cycle and compares against the queue.
module tb_uart_tx_mmio;

   localparam int          CPB  = 4;
   localparam int          DL2  = 2;
   localparam logic [31:0] BASE = 32'h40000018;
   localparam logic [31:0] STAT = BASE + 32'd4;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Hit;
   logic        tx;
   logic        irq;

   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   logic [7:0]  exp_q[$];
   int          start_q[$];

   uart_tx_mmio #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH_LOG2(DL2),
      .BASE_ADDR(BASE)
   ) dut (
      .clk(clk),
      .reset(reset),
      .MemRead(MemRead),
      .MemWrite(MemWrite),
      .Address(Address),
      .WriteData(WriteData),
      .ReadData(ReadData),
      .Hit(Hit),
      .tx(tx),
      .irq(irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected 40-sample line pattern of one 8N1 frame at CPB=4, LSB first.
   function automatic logic [39:0] frame_bits(input logic [7:0] b);
      logic [39:0] f;
      for (int k = 0; k < 40; k++) begin
         if (k < 4) f[k] = 1'b0;
         else if (k < 36) f[k] = b[(k - 4) / 4];
         else f[k] = 1'b1;
      end
      return f;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Line monitor: detect a start bit, sample 40 cycles, compare to the oldest queued byte.
   initial begin : monitor
      logic [39:0] seen;
      logic [7:0]  exp_b;
      bit          aborted;
      forever begin
         @(negedge clk);
         if (reset !== 1'b0 || tx !== 1'b0) continue;
         start_q.push_back(cyc);
         seen    = '0;
         seen[0] = tx;
         aborted = 1'b0;
         for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            if (reset !== 1'b0) begin
               aborted = 1'b1;
               break;
            end
            seen[k] = tx;
         end
         if (!aborted) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_frame: got line 0x%010h expected no frame", seen);
            end else begin
               exp_b = exp_q.pop_front();
               if (seen !== frame_bits(exp_b)) begin
                  failures++;
                  $display("FAIL frame_bits: got line 0x%010h expected 0x%010h (byte 0x%02h)",
                           seen, frame_bits(exp_b), exp_b);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
      MemWrite  = 1'b1;
      Address   = addr;
      WriteData = data;
      tick();
      MemWrite  = 1'b0;
      Address   = 32'd0;
   endtask

   task automatic push_byte(input logic [7:0] b, input bit accepted);
      logic [31:0] r;
      r = $urandom();
      if (accepted) exp_q.push_back(b);
      do_write(BASE, {r[31:8], b});
   endtask

   task automatic read_at(input logic [31:0] addr, input logic rd, input logic [31:0] exp,
                          input logic exp_hit, input string name);
      MemRead = rd;
      Address = addr;
      #1;
      check32(name, ReadData, exp);
      check32({name, "_hit"}, {31'd0, Hit}, {31'd0, exp_hit});
      MemRead = 1'b0;
      Address = 32'd0;
   endtask

   task automatic read_status(input logic [31:0] exp, input string name);
      read_at(STAT, 1'b1, exp, 1'b1, name);
   endtask

   task automatic check_irq(input logic exp_en, input string name);
`ifdef UART_TX_IRQ_EN
      check32(name, {31'd0, irq}, {31'd0, exp_en});
`else
      check32(name, {31'd0, irq}, {31'd0, 1'b0 & exp_en});
`endif
   endtask

   task automatic check_start(input int exp, input string name);
      if (start_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: got no frame start expected start at cycle %0d", name, exp);
      end else begin
         check32(name, start_q.pop_front(), exp);
      end
   endtask

   // Status word from the register map: busy, full, empty, overflow, count.
   function automatic logic [31:0] st(input bit busy, input bit full, input bit empty,
                                      input bit ovf, input int count);
      return {23'd0, 5'(count), ovf, empty, full, busy};
   endfunction

   initial begin : stimulus
      int w;
      int k;
      int last;
      reset     = 1'b1;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      Address   = 32'd0;
      WriteData = 32'd0;
      repeat (3) tick();

      // Reset state
      check32("reset_tx", {31'd0, tx}, 32'd1);
      check_irq(1'b0, "reset_irq");
      read_status(st(0, 0, 1, 0, 0), "reset_status");
      reset = 1'b0;
      tick();
      check_irq(1'b1, "idle_irq");
      read_at(STAT, 1'b0, 32'd0, 1'b1, "noread_status");
      read_at(BASE, 1'b1, 32'd0, 1'b1, "read_data_reg");
      read_at(BASE + 32'd8, 1'b1, 32'd0, 1'b0, "read_other");

      // Single byte
      push_byte(8'h55, 1'b1);
      w = cyc;
      read_status(st(0, 0, 0, 0, 1), "push_status");
      check_irq(1'b0, "push_irq");
      tick();
      read_status(st(1, 0, 1, 0, 0), "popped_status");
      wait_until(w + 40);
      read_status(st(1, 0, 1, 0, 0), "last_stop_busy");
      tick();
      read_status(st(0, 0, 1, 0, 0), "single_idle");
      check_irq(1'b1, "single_irq_back");
      check_start(w + 1, "single_start");

      // Back-to-back
      tick();
      push_byte(8'hA5, 1'b1);
      w = cyc;
      push_byte(8'h0F, 1'b1);
      wait_until(w + 41);
      read_status(st(1, 0, 1, 0, 0), "b2b_empty");
      wait_until(w + 82);
      read_status(st(0, 0, 1, 0, 0), "b2b_idle");
      check_start(w + 1, "b2b_start1");
      check_start(w + 41, "b2b_nogap");

      // Overflow, then a write on the exact STOP->START pop edge while full
      tick();
      push_byte(8'($urandom()), 1'b1);
      w = cyc;
      tick();
      for (int i = 0; i < 4; i++) push_byte(8'($urandom()), 1'b1);
      push_byte(8'($urandom()), 1'b0);
      read_status(st(1, 1, 0, 1, 4), "ovf_status");
      check_irq(1'b0, "ovf_irq");
      do_write(STAT, 32'h0000_0008);
      read_status(st(1, 1, 0, 0, 4), "ovf_cleared");
      wait_until(w + 40);
      push_byte(8'($urandom()), 1'b1);
      read_status(st(1, 1, 0, 0, 4), "full_pop_write");
      wait_until(w + 242);
      read_status(st(0, 0, 1, 0, 0), "ovf_drained");
      for (int i = 0; i < 6; i++) check_start(w + 1 + 40 * i, "ovf_frame_start");

      // Reset during DATA bit 3 with two bytes queued
      tick();
      push_byte(8'($urandom()), 1'b1);
      w = cyc;
      push_byte(8'($urandom()), 1'b1);
      push_byte(8'($urandom()), 1'b1);
      wait_until(w + 18);
      reset = 1'b1;
      exp_q.delete();
      tick();
      reset = 1'b0;
      check32("rst_tx", {31'd0, tx}, 32'd1);
      read_status(st(0, 0, 1, 0, 0), "rst_status");
      check_irq(1'b0, "rst_irq");
      check_start(w + 1, "rst_frame_start");
      repeat (100) tick();
      check32("rst_no_frames", start_q.size(), 32'd0);
      check_irq(1'b1, "rst_irq_idle");

      // Randomized bursts that never overfill the FIFO
      for (int r = 0; r < 6; r++) begin
         k = $urandom_range(1, 4);
         for (int j = 0; j < k; j++) begin
            push_byte(8'($urandom()), 1'b1);
            repeat ($urandom_range(0, 2)) tick();
         end
         last = cyc;
         wait_until(last + 40 * k + 45);
         read_status(st(0, 0, 1, 0, 0), "rand_drain");
         check_irq(1'b1, "rand_irq");
         start_q.delete();
      end

      check32("scoreboard_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter attached to the data-memory port of the 5-stage pipeline, alongside the data memory in the MEM stage. A store from the MEM stage to the TX data address pushes a byte into a small FIFO. A store to the status address can clear the overflow flag. A load from the status address returns FIFO and serializer state in the same cycle. A baud-rate FSM drains the FIFO onto a single serial line as 8N1 frames.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per serial bit; legal range 2..65535.
- `FIFO_DEPTH_LOG2`, 2: FIFO depth is 2^FIFO_DEPTH_LOG2 entries; legal range 1..4.
- `BASE_ADDR`, 32'h40000018: TX data register address. Status register is at BASE_ADDR+4.
- `clk`  in  1: system clock, the same clock as the pipeline.
- `reset`  in  1: synchronous, active-high reset.
- `MemRead`  in  1: MEM-stage load enable.
- `MemWrite`  in  1: MEM-stage store enable.
- `Address`  in  32: MEM-stage byte address (the ALU output).
- `WriteData`  in  32: MEM-stage store data; only bits [7:0] are used for TX data.
- `ReadData`  out  32: status readback; combinational.
- `Hit`  out  1: Address matches either register; the top level uses this to mux ReadData over data-memory output.
- `tx`  out  1: serial output, registered, idle high.
- `irq`  out  1: TX-empty interrupt (see Configuration).

## Operation
- **Data write:** `MemWrite` high and `Address==BASE_ADDR` pushes `WriteData[7:0]` at the clock edge.
  - If the FIFO is full and no pop occurs on the same edge, the byte is dropped and sticky `overflow` is set.
- **Status write:** `MemWrite` high and `Address==BASE_ADDR+4` with `WriteData[3]==1` clears `overflow`. All other bits are ignored.
- **Status read:** when `MemRead` is high and `Address==BASE_ADDR+4`, `ReadData` returns:
  - [0] `busy`: FSM not in IDLE.
  - [1] `full`.
  - [2] `empty`.
  - [3] `overflow`.
  - [8:4] FIFO `count` (0..16).
  - [31:9] zero.
- **Other reads:** any other address, or a read of BASE_ADDR, returns 0. Reads have no side effects.
- **FIFO:** circular buffer with read and write pointers of width FIFO_DEPTH_LOG2, wrapping modulo depth, plus a count register of width FIFO_DEPTH_LOG2+1.
  - Simultaneous push and pop: count unchanged, both pointers advance. This also applies when the FIFO is full.
- **FSM states:** IDLE, START, DATA, STOP. A baud counter counts 0..CLKS_PER_BIT-1, and a bit index counts 0..7.
  - IDLE: `tx=1`. If the FIFO is not empty, pop into the shift register and go to START.
  - START: `tx=0` for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx=shift[0]`, sent LSB first. Shift right after each CLKS_PER_BIT period. After bit 7, go to STOP.
  - STOP: `tx=1` for CLKS_PER_BIT cycles. At the end, if the FIFO is not empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- **Reset values:** `tx=1`, `irq=0`, state IDLE, pointers, count and `overflow` all 0, shift register 0. `ReadData` is 0 because the address is undecoded.
- **Reset mid-frame:** the frame is aborted, `tx` is 1 from the next edge, and FIFO contents are discarded.

## Timing
- A push at edge N makes the FIFO non-empty after N.
- If the FSM is in IDLE, it pops at edge N+1 and `tx` falls after N+1.
- Frame length is exactly 10×CLKS_PER_BIT cycles.
- Back-to-back frames have no gap.
- `busy` reads 1 from the cycle after the pop edge until the cycle after the final STOP edge.
- `full` and `count` reflect a push on the cycle after its edge. A same-cycle status read shows the pre-edge values.

## Configuration
- `UART_TX_IRQ_EN` defined: `irq` is a registered level output, high when the FIFO is empty and the FSM is in IDLE, and low otherwise. It deasserts on the edge after a push. It is 0 during reset.
- `UART_TX_IRQ_EN` undefined: `irq` is tied to 0 and no interrupt logic is generated.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH_LOG2=2.

- **Single byte:** reset, then write 0x55 to BASE_ADDR.
  - `tx` reads 0,1,0,1,0,1,0,1,0 (start bit, then data LSB first), then 1 for stop, each bit held for 4 cycles.
  - The total frame is 40 cycles.
  - `busy` falls after the frame.
- **Back-to-back:** write 0xA5 and 0x0F on consecutive cycles.
  - Two frames with no idle high cycle between the stop of frame 1 and the start of frame 2.
  - `empty`=1 after the second pop.
- **Overflow:** while frame 1 is sending, write 5 more bytes.
  - The 5th extra byte is dropped and status reads `overflow`=1, `full`=1, `count`=4.
  - Writing 0x8 to BASE_ADDR+4 clears `overflow`. Only the 5 accepted bytes are transmitted.
- **Full with simultaneous pop:** fill the FIFO to 4 and write on the exact edge of the STOP→START pop.
  - The write is accepted, `count` stays 4, and no overflow is flagged.
- **Reset mid-frame:** assert `reset` for 1 cycle during DATA bit 3 with 2 bytes queued.
  - `tx`=1 the next cycle, status reads 0x4 (empty only), and no further frames are sent.
- **IRQ:** with the macro defined, `irq`=1 after reset; a write drops it on the next edge; it returns to 1 after the last stop bit. With the macro undefined, `irq` stays 0 throughout.
